// File: rtl/vend_pkg.sv
// Shared types for the vending sequencer: state codes double as 7-segment display codes.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_COLLECT = 4'h1,
    ST_VEND    = 4'h3,
    ST_CHANGE  = 4'h4,
    ST_ERROR   = 4'hE
  } state_e;

  // Product number is also its price in coin units; 0 means nothing selected.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [2:0] sel);
    return CREDIT_W'(sel);
  endfunction

endpackage

// File: rtl/vend_sequencer_debounce_edge.sv
// Button front end: 2-FF synchronizer, counting debouncer and registered rising-edge event.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: debounced buttons, credit accumulation, vend / change / error sequencing.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned DISPENSE_CYCLES = 8,
  parameter int unsigned CHANGE_GAP      = 4,
  parameter int unsigned ERR_CYCLES      = 8,
  parameter int unsigned MAX_CREDIT      = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                coin_in,
  input  logic                avance_in,
  input  logic                cancel_in,
  input  logic [2:0]          sw_sel,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          estado_actual,
  output logic                dispense,
  output logic                refund,
  output logic                coin_reject,
  output logic                busy
);

  localparam int unsigned T_A   = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ? TIMEOUT_CYCLES : DISPENSE_CYCLES;
  localparam int unsigned T_B   = (CHANGE_GAP > ERR_CYCLES) ? CHANGE_GAP : ERR_CYCLES;
  localparam int unsigned TMAX  = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TMR_W = $clog2(TMAX + 1);

  logic [2:0] btn_level_unused;
  logic       coin_rise, avance_rise, cancel_rise;
  logic       coin_ev, avance_ev, cancel_ev;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk(clk), .rst_n(rst_n), .btn_i(coin_in), .level(btn_level_unused[0]), .rise(coin_rise)
  );
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_avance (
    .clk(clk), .rst_n(rst_n), .btn_i(avance_in), .level(btn_level_unused[1]), .rise(avance_rise)
  );
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(clk), .rst_n(rst_n), .btn_i(cancel_in), .level(btn_level_unused[2]), .rise(cancel_rise)
  );

  assign coin_ev   = ena & coin_rise;
  assign avance_ev = ena & avance_rise;
  assign cancel_ev = ena & cancel_rise;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                dispense_q, dispense_d;
  logic                refund_q, refund_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price, sub;
  logic                add, avance_ok, buy, refund_tick;

  assign price     = price_of(sw_sel);
  assign avance_ok = (price != '0) && (credit_q >= price);

  // Credit arithmetic is settled first so state decisions can see the post-coin, post-refund value.
  always_comb begin
    add         = coin_ev && (credit_q != CREDIT_W'(MAX_CREDIT));
    reject_d    = coin_ev && (credit_q == CREDIT_W'(MAX_CREDIT));
    buy         = (state_q == ST_COLLECT) && avance_ev && !cancel_ev && avance_ok;
    refund_tick = ena && (state_q == ST_CHANGE) && (timer_q == TMR_W'(CHANGE_GAP - 1))
                  && (credit_q != '0);
    refund_d    = refund_tick;
    sub         = '0;
    if (refund_tick) sub = CREDIT_W'(1);
    else if (buy)    sub = price;
    credit_d    = credit_q + CREDIT_W'(add) - sub;

    state_d = state_q;
    timer_d = timer_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (add) state_d = ST_COLLECT;
        end
        ST_COLLECT: begin
          timer_d = timer_q + 1'b1;
          if (cancel_ev) begin
            state_d = ST_CHANGE;
            timer_d = '0;
          end else if (avance_ev) begin
            state_d = buy ? ST_VEND : ST_ERROR;
            timer_d = '0;
          end else if (coin_ev) begin
            timer_d = '0;
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_CHANGE;
            timer_d = '0;
          end
        end
        ST_ERROR: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TMR_W'(ERR_CYCLES - 1)) begin
            state_d = ST_COLLECT;
            timer_d = '0;
          end
        end
        ST_VEND: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TMR_W'(DISPENSE_CYCLES - 1)) begin
            state_d = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
            timer_d = '0;
          end
        end
        ST_CHANGE: begin
          timer_d = refund_tick ? '0 : timer_q + 1'b1;
          if (credit_d == '0) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end

    dispense_d = (state_d == ST_VEND);
    busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      timer_q    <= '0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign credit        = credit_q;
  assign estado_actual = state_q;
  assign dispense      = dispense_q;
  assign refund        = refund_q;
  assign coin_reject   = reject_q;
  assign busy          = busy_q;

endmodule
